// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel debouncer.
// Holds the channel state enum, counter width helper and PS/2 idle level.
package debounce_pkg;

    typedef enum logic {
        IDLE,
        SETTLING
    } state_e;

    // PS/2 clock and data idle high, so every channel resets to 1.
    localparam logic [31:0] PS2_IDLE_LEVEL = '1;

    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, result, edge pulses.
// Ports: clk, reset (async high), tick, din -> result, rise, fall, edge_d.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 524288,
    parameter int   SYNC_STAGES   = 2,
    parameter logic RESET_VAL     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic result,
    output logic rise,
    output logic fall,
    output logic edge_d
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   result_q;
    logic                   result_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   s;
    state_e                 state;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
    assign s      = sync_q[SYNC_STAGES-1];
    assign state  = (s != result_q) ? SETTLING : IDLE;

    always_comb begin
        cnt_d    = cnt_q;
        result_d = result_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        unique case (state)
            IDLE: begin
                // Any return to the accepted level discards the window.
                cnt_d = '0;
            end
            SETTLING: begin
                if (tick) begin
                    if (cnt_q == LAST) begin
                        result_d = s;
                        cnt_d    = '0;
                        rise_d   = s;
                        fall_d   = ~s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            cnt_q    <= '0;
            result_q <= RESET_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign result = result_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    // Next-cycle edge, so the top can register any_edge alongside the pulses.
    assign edge_d = rise_d | fall_d;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: CHANNELS independent lines with shared tick.
// Ports: clk, reset, tick, din -> result, rise, fall, any_edge.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  STABLE_CYCLES = 524288,
    parameter int                  SYNC_STAGES   = 2,
    parameter logic [CHANNELS-1:0] RESET_VAL     =
        PS2_IDLE_LEVEL[CHANNELS-1:0]
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] result,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_edge
);

    logic [CHANNELS-1:0] edge_d;
    logic                any_edge_d;
    logic                any_edge_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_VAL     (RESET_VAL[i])
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .din    (din[i]),
            .result (result[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .edge_d (edge_d[i])
        );
    end

    always_comb begin
        any_edge_d = |edge_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_edge_q <= 1'b0;
        end else begin
            any_edge_q <= any_edge_d;
        end
    end

    assign any_edge = any_edge_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (STABLE_CYCLES=8 and =3 instances).
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick8;
    logic [3:0] din8;
    logic [3:0] res8, rise8, fall8;
    logic       any8;
    logic       tick3;
    logic [3:0] din3;
    logic [3:0] res3, rise3, fall3;
    logic       any3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(8)) dut8 (
        .clk(clk), .reset(reset), .tick(tick8), .din(din8),
        .result(res8), .rise(rise8), .fall(fall8), .any_edge(any8)
    );

    debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .tick(tick3), .din(din3),
        .result(res3), .rise(rise3), .fall(fall3), .any_edge(any3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick8 = 1'b1;
        tick3 = 1'b1;
        din8  = 4'hF;
        din3  = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({res8, rise8, fall8, any8} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold got=%h/%h/%h/%b want=F/0/0/0",
                     res8, rise8, fall8, any8);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if ({res8, rise8, fall8, any8, res3, rise3, fall3, any3} !==
                {4'hF, 4'h0, 4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL reset_idle[%0d] got=%h/%h/%h/%b want=F/0/0/0",
                         i, res8, rise8, fall8, any8);
            end
        end
    endtask

    task automatic test_clean_fall();
        din8 = 4'hE;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if ({res8, rise8, fall8, any8} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL fall_early[%0d] got=%h/%h/%h/%b want=F/0/0/0",
                         i, res8, rise8, fall8, any8);
            end
        end
        step();
        total++;
        if ({res8, rise8, fall8, any8} !== {4'hE, 4'h0, 4'h1, 1'b1}) begin
            bad++;
            $display("FAIL fall_edge got=%h/%h/%h/%b want=E/0/1/1",
                     res8, rise8, fall8, any8);
        end
        step();
        total++;
        if ({res8, rise8, fall8, any8} !== {4'hE, 4'h0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL fall_after got=%h/%h/%h/%b want=E/0/0/0",
                     res8, rise8, fall8, any8);
        end
        din8 = 4'hF;
        repeat (12) step();
        total++;
        if ({res8, rise8, fall8, any8} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL fall_restore got=%h/%h/%h/%b want=F/0/0/0",
                     res8, rise8, fall8, any8);
        end
    endtask

    task automatic test_bounce();
        din8 = 4'hD;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) din8 = 4'hF;
            step();
            total++;
            if ({res8, rise8, fall8, any8} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL bounce_pre[%0d] got=%h/%h/%h/%b want=F/0/0/0",
                         i, res8, rise8, fall8, any8);
            end
        end
        din8 = 4'hD;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if ({res8, rise8, fall8, any8} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL bounce_wait[%0d] got=%h/%h/%h/%b want=F/0/0/0",
                         i, res8, rise8, fall8, any8);
            end
        end
        step();
        total++;
        if ({res8, rise8, fall8, any8} !== {4'hD, 4'h0, 4'h2, 1'b1}) begin
            bad++;
            $display("FAIL bounce_edge got=%h/%h/%h/%b want=D/0/2/1",
                     res8, rise8, fall8, any8);
        end
        din8 = 4'hF;
        repeat (12) step();
        total++;
        if (res8 !== 4'hF) begin
            bad++;
            $display("FAIL bounce_restore got=%h want=F", res8);
        end
    endtask

    task automatic test_tick_gating();
        tick3 = 1'b0;
        din3  = 4'hB;
        for (int e = 0; e <= 12; e++) begin
            tick3 = (e > 0) && (e % 4 == 0);
            step();
            total++;
            if (e < 12) begin
                if ({res3, fall3, any3} !== {4'hF, 4'h0, 1'b0}) begin
                    bad++;
                    $display("FAIL tick_wait[%0d] got=%h/%h/%b want=F/0/0",
                             e, res3, fall3, any3);
                end
            end else begin
                if ({res3, rise3, fall3, any3} !== {4'hB, 4'h0, 4'h4, 1'b1}) begin
                    bad++;
                    $display("FAIL tick_edge got=%h/%h/%h/%b want=B/0/4/1",
                             res3, rise3, fall3, any3);
                end
            end
        end
        tick3 = 1'b1;
        din3  = 4'hF;
        repeat (8) step();
        total++;
        if (res3 !== 4'hF) begin
            bad++;
            $display("FAIL tick_restore got=%h want=F", res3);
        end
    endtask

    task automatic test_simultaneous();
        din8 = 4'hE;
        repeat (12) step();
        din8 = 4'h7;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if ({res8, rise8, fall8, any8} !== {4'hE, 4'h0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL simul_wait[%0d] got=%h/%h/%h/%b want=E/0/0/0",
                         i, res8, rise8, fall8, any8);
            end
        end
        step();
        total++;
        if ({res8, rise8, fall8, any8} !== {4'h7, 4'h1, 4'h8, 1'b1}) begin
            bad++;
            $display("FAIL simul_edge got=%h/%h/%h/%b want=7/1/8/1",
                     res8, rise8, fall8, any8);
        end
        step();
        total++;
        if ({res8, rise8, fall8, any8} !== {4'h7, 4'h0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL simul_after got=%h/%h/%h/%b want=7/0/0/0",
                     res8, rise8, fall8, any8);
        end
        din8 = 4'hF;
        repeat (12) step();
        total++;
        if (res8 !== 4'hF) begin
            bad++;
            $display("FAIL simul_restore got=%h want=F", res8);
        end
    endtask

    task automatic test_reset_mid_settle();
        din8 = 4'hE;
        repeat (12) step();
        din8 = 4'hC;
        for (int i = 0; i < 7; i++) begin
            step();
            total++;
            if ({res8, rise8, fall8, any8} !== {4'hE, 4'h0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL midrst_pre[%0d] got=%h/%h/%h/%b want=E/0/0/0",
                         i, res8, rise8, fall8, any8);
            end
        end
        #2;
        reset = 1'b1;
        din8  = 4'hD;
        #1;
        total++;
        if ({res8, rise8, fall8, any8} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL midrst_async got=%h/%h/%h/%b want=F/0/0/0",
                     res8, rise8, fall8, any8);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if ({res8, rise8, fall8, any8} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
                bad++;
                $display("FAIL midrst_wait[%0d] got=%h/%h/%h/%b want=F/0/0/0",
                         i, res8, rise8, fall8, any8);
            end
        end
        step();
        total++;
        if ({res8, rise8, fall8, any8} !== {4'hD, 4'h0, 4'h2, 1'b1}) begin
            bad++;
            $display("FAIL midrst_edge got=%h/%h/%h/%b want=D/0/2/1",
                     res8, rise8, fall8, any8);
        end
        din8 = 4'hF;
        repeat (12) step();
        total++;
        if (res8 !== 4'hF) begin
            bad++;
            $display("FAIL midrst_restore got=%h want=F", res8);
        end
    endtask

    initial begin
        test_reset();
        test_clean_fall();
        test_bounce();
        test_tick_gating();
        test_simultaneous();
        test_reset_mid_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
